// File: rtl/id_exe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_pipe_reg
// Description : ID/EXE pipeline register for the 5-stage MIPS core, with
//               flush/stall handling, an integrated load-use hazard detector
//               and a saturating bubble counter for performance monitoring.
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4,
  parameter int BCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              aluimm,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic [REG_AW-1:0] mux,
  input  logic [DATA_W-1:0] regOutA,
  input  logic [DATA_W-1:0] regOutB,
  input  logic [DATA_W-1:0] extended,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              evalid,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic [ALUC_W-1:0] ealuc,
  output logic [REG_AW-1:0] emux,
  output logic [DATA_W-1:0] eRegOutA,
  output logic [DATA_W-1:0] eRegOutB,
  output logic [DATA_W-1:0] eExtended,
  output logic              load_use_stall,
  output logic [BCNT_W-1:0] bubble_count
);

  localparam logic [REG_AW-1:0] C_REG_ZERO = '0;
  localparam logic [BCNT_W-1:0] C_CNT_MAX  = '1;

  logic w_rs_match;
  logic w_rt_match;
  logic w_hazard;
  logic w_bubble;

  // Load-use detection: a valid load in EXE whose destination (never $0)
  // is read by the valid instruction currently in ID.
  always_comb begin
    w_rs_match     = uses_rs && (rs == emux);
    w_rt_match     = uses_rt && (rt == emux);
    w_hazard       = in_valid && evalid && em2reg && ewreg &&
                     (emux != C_REG_ZERO) && (w_rs_match || w_rt_match);
    // A flush squashes the ID instruction too, so no upstream freeze is needed.
    load_use_stall = w_hazard && !flush;
    // A bubble is written on flush, or on a hazard when not held downstream.
    w_bubble       = flush || (w_hazard && !ext_stall);
  end

  // Pipeline register: rst > flush > ext_stall > hazard > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      evalid    <= 1'b0;
      ewreg     <= 1'b0;
      em2reg    <= 1'b0;
      ewmem     <= 1'b0;
      ealuimm   <= 1'b0;
      ealuc     <= '0;
      emux      <= '0;
      eRegOutA  <= '0;
      eRegOutB  <= '0;
      eExtended <= '0;
    end else if (w_bubble) begin
      // Bubble: kill the control fields, leave the data fields untouched.
      evalid    <= 1'b0;
      ewreg     <= 1'b0;
      em2reg    <= 1'b0;
      ewmem     <= 1'b0;
      ealuimm   <= 1'b0;
      ealuc     <= '0;
      emux      <= '0;
    end else if (!ext_stall) begin
      evalid    <= in_valid;
      ewreg     <= wreg;
      em2reg    <= m2reg;
      ewmem     <= wmem;
      ealuimm   <= aluimm;
      ealuc     <= aluc;
      emux      <= mux;
      eRegOutA  <= regOutA;
      eRegOutB  <= regOutB;
      eExtended <= extended;
    end
  end

  // Saturating count of written bubbles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (w_bubble && (bubble_count != C_CNT_MAX)) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule
`default_nettype wire
